// File: rtl/axi_stream_insert_arbiter_if.sv
// axi_stream_insert_arbiter_if: per-source data/header channels plus the shared downstream insert channels
interface axi_stream_insert_arbiter_if #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic [NUM_SRC-1:0]              s_valid_in;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [NUM_SRC-1:0]              s_last_in;
  logic [NUM_SRC-1:0]              s_ready_in;
  logic [NUM_SRC-1:0]              s_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt;
  logic [NUM_SRC-1:0]              s_ready_insert;
  logic                            valid_in;
  logic [DATA_WD-1:0]              data_in;
  logic [DATA_BYTE_WD-1:0]         keep_in;
  logic                            last_in;
  logic                            ready_in;
  logic                            valid_insert;
  logic [DATA_WD-1:0]              data_insert;
  logic [DATA_BYTE_WD-1:0]         keep_insert;
  logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
  logic                            ready_insert;
  modport slave (
    input  s_valid_in, s_data_in, s_keep_in, s_last_in, s_valid_insert, s_data_insert,
           s_keep_insert, s_byte_insert_cnt, ready_in, ready_insert,
    output s_ready_in, s_ready_insert, valid_in, data_in, keep_in, last_in,
           valid_insert, data_insert, keep_insert, byte_insert_cnt
  );
  modport master (
    output s_valid_in, s_data_in, s_keep_in, s_last_in, s_valid_insert, s_data_insert,
           s_keep_insert, s_byte_insert_cnt, ready_in, ready_insert,
    input  s_ready_in, s_ready_insert, valid_in, data_in, keep_in, last_in,
           valid_insert, data_insert, keep_insert, byte_insert_cnt
  );
endinterface

// File: rtl/axi_stream_insert_arbiter.sv
// axi_stream_insert_arbiter: packet-level round-robin arbiter sharing one header-insert datapath
module axi_stream_insert_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  axi_stream_insert_arbiter_if.slave    bus,
  output logic [SRC_ID_WD-1:0]          grant_id,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state_q, state_d;
  logic [SRC_ID_WD-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic found, in_hdr, in_data;
  // first requesting source at or above rr_q, wrapping explicitly so unused codes never appear
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && bus.s_valid_insert[(int'(rr_q) + k) % NUM_SRC]) begin
        found = 1'b1;
        pick = SRC_ID_WD'((int'(rr_q) + k) % NUM_SRC);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        state_d = HDR;
      end
      HDR: if (bus.valid_insert && bus.ready_insert) state_d = DATA;
      DATA: if (bus.valid_in && bus.ready_in && bus.last_in) begin
        state_d = IDLE;
        rr_d = (grant_q == SRC_ID_WD'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
    end
  end
  assign in_hdr = state_q == HDR;
  assign in_data = state_q == DATA;
  assign bus.valid_insert = in_hdr & bus.s_valid_insert[grant_q];
  assign bus.data_insert = bus.s_data_insert[grant_q*DATA_WD +: DATA_WD];
  assign bus.keep_insert = bus.s_keep_insert[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign bus.byte_insert_cnt = bus.s_byte_insert_cnt[grant_q*BYTE_CNT_WD +: BYTE_CNT_WD];
  assign bus.s_ready_insert = in_hdr ? NUM_SRC'(bus.ready_insert) << grant_q : '0;
  assign bus.valid_in = in_data & bus.s_valid_in[grant_q];
  assign bus.data_in = bus.s_data_in[grant_q*DATA_WD +: DATA_WD];
  assign bus.keep_in = bus.s_keep_in[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign bus.last_in = bus.s_last_in[grant_q];
  assign bus.s_ready_in = in_data ? NUM_SRC'(bus.ready_in) << grant_q : '0;
  assign grant_id = grant_q;
  assign busy = state_q != IDLE;
endmodule
